axi_lite_cmd_master: RTL and testbench

//  Upstream driver for the AXI-lite register slave. Converts a simple single-beat command/response

---
 rtl/axi_lite_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding command/response to AXI-lite master bridge; every output is a flop.
// Define AXIL_TIMEOUT_EN to add a watchdog that aborts a stuck transaction with rsp_resp=2'b11.
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARST_N,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic                    AW_VALID,
    input  logic                    AW_READY,
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_VALID,
    input  logic                    W_READY,
    input  logic [1:0]              B_RESP,
    input  logic                    B_VALID,
    output logic                    B_READY,
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]              R_RESP,
    input  logic                    R_VALID,
    output logic                    R_READY,
    output logic [2:0]              dbg_state_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    r_ready_q, r_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
`ifdef AXIL_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXIL_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
`ifdef AXIL_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    if (cmd_wr) begin
                        state_d    = WR_AW_W;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_AR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // Each channel retires independently; B_READY only rises once both have.
                if (AW_READY) aw_valid_d = 1'b0;
                if (W_READY)  w_valid_d  = 1'b0;
                if ((!aw_valid_q || AW_READY) && (!w_valid_q || W_READY)) begin
                    state_d   = WR_B;
                    b_ready_d = 1'b1;
                end
            end
            WR_B: begin
                if (B_VALID && b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = B_RESP;
                    state_d     = RSP;
                end
            end
            RD_AR: begin
                if (AR_READY && ar_valid_q) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_R;
                end
            end
            RD_R: begin
                if (R_VALID && r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = R_DATA;
                    rsp_resp_d  = R_RESP;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        // Watchdog overrides any handshake landing on the final cycle.
        if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_resp_d  = 2'b11;
                state_d     = RSP;
            end
        end
`endif
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign AW_ADDR     = addr_q;
    assign AW_VALID    = aw_valid_q;
    assign W_DATA      = wdata_q;
    assign W_STRB      = wstrb_q;
    assign W_VALID     = w_valid_q;
    assign B_READY     = b_ready_q;
    assign AR_ADDR     = addr_q;
    assign AR_VALID    = ar_valid_q;
    assign R_READY     = r_ready_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: vector table through a small AXI-lite slave model,
// plus hand-written reset-abort and (with AXIL_TIMEOUT_EN) watchdog sequences.
module tb_axi_lite_cmd_master;
  localparam int TO = 16;

  logic        ACLK = 1'b0;
  logic        ARST_N = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AW_ADDR, AR_ADDR;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [31:0] W_DATA, R_DATA;
  logic [3:0]  W_STRB;
  logic [1:0]  B_RESP, R_RESP;
  logic [2:0]  dbg_state_o;

  axi_lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARST_N(ARST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  // slave model: registered B/R one cycle after the request completes
  logic        b_en = 1'b1;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] mem [4];
  logic        s_aw, s_w;
  logic [3:0]  s_addr, s_ws;
  logic [31:0] s_wd;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic aw_hs, w_hs, aw_have, w_have;
  logic [3:0]  cur_addr, cur_ws;
  logic [31:0] cur_wd;
  assign aw_hs    = AW_VALID && AW_READY;
  assign w_hs     = W_VALID && W_READY;
  assign aw_have  = s_aw || aw_hs;
  assign w_have   = s_w || w_hs;
  assign cur_addr = aw_hs ? AW_ADDR : s_addr;
  assign cur_wd   = w_hs ? W_DATA : s_wd;
  assign cur_ws   = w_hs ? W_STRB : s_ws;

  always @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      s_aw <= 1'b0; s_w <= 1'b0; s_addr <= '0; s_wd <= '0; s_ws <= '0;
      B_VALID <= 1'b0; B_RESP <= '0; R_VALID <= 1'b0; R_DATA <= '0; R_RESP <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (B_VALID && B_READY) begin B_VALID <= 1'b0; b_cnt <= b_cnt + 1; end
      if (R_VALID && R_READY) begin R_VALID <= 1'b0; r_cnt <= r_cnt + 1; end
      if (aw_hs) begin s_addr <= AW_ADDR; aw_cnt <= aw_cnt + 1; end
      if (w_hs) begin s_wd <= W_DATA; s_ws <= W_STRB; w_cnt <= w_cnt + 1; end
      if (aw_have && w_have && b_en) begin
        for (int b = 0; b < 4; b++)
          if (cur_ws[b]) mem[cur_addr[3:2]][8*b +: 8] <= cur_wd[8*b +: 8];
        B_VALID <= 1'b1; B_RESP <= slv_resp; s_aw <= 1'b0; s_w <= 1'b0;
      end else begin
        s_aw <= aw_have; s_w <= w_have;
      end
      if (AR_VALID && AR_READY) begin
        R_VALID <= 1'b1; R_DATA <= mem[AR_ADDR[3:2]]; R_RESP <= slv_resp; ar_cnt <= ar_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  slv_resp;
    int          w_dly;
    int          rsp_stall;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [1:0] sr, input int w_dly,
                              input int stall, input logic [31:0] er, input logic [1:0] ep);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.slv_resp = sr;
    v.w_dly = w_dly; v.rsp_stall = stall; v.exp_rdata = er; v.exp_resp = ep;
    return v;
  endfunction

  // driver: issue one command, follow it through the AXI side, consume the response
  task automatic run_cmd(input vec_t v);
    int c, n;
    int aw0, w0, b0, ar0, r0;
    logic [33:0] snap, exp;
    exp_q.push_back({v.exp_rdata, v.exp_resp});
    slv_resp = v.slv_resp;
    W_READY = (v.w_dly == 0);
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    check("cmd_accept", 64'(n < 20), 64'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    c = 1;
    if (v.wr) begin
      check("wr_valids_c1", {AW_VALID, W_VALID, AR_VALID, cmd_ready}, 4'b1100);
      check("wr_payload", {AW_ADDR, W_DATA, W_STRB}, {v.addr, v.wdata, v.wstrb});
    end else begin
      check("rd_valids_c1", {AR_VALID, AW_VALID, W_VALID, cmd_ready}, 4'b1000);
      check("rd_addr", 64'(AR_ADDR), 64'(v.addr));
    end
    while (!rsp_valid && c < 200) begin
      if (v.w_dly > 0 && c >= 2 && c <= v.w_dly + 1)
        check("w_stall_hold", {AW_VALID, W_VALID, B_READY, W_DATA}, {1'b0, 1'b1, 1'b0, v.wdata});
      if (v.w_dly > 0 && c == v.w_dly + 1) W_READY = 1'b1;
      @(negedge ACLK);
      c++;
    end
    check("rsp_arrives", 64'(c < 200), 64'd1);
    if (v.w_dly == 0) check("latency_incl_accept", 64'(c + 1), 64'd4);
    snap = {rsp_rdata, rsp_resp};
    for (int s = 0; s < v.rsp_stall; s++) begin
      check("rsp_stall_hold", {rsp_valid, cmd_ready, rsp_rdata, rsp_resp}, {1'b1, 1'b0, snap});
      @(negedge ACLK);
    end
    rsp_ready = 1'b1;
    exp = exp_q.pop_front();
    check("rsp_data_resp", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, exp});
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {rsp_valid, cmd_ready, dbg_state_o}, {1'b0, 1'b1, 3'd0});
    check("handshake_counts",
          {4'(aw_cnt - aw0), 4'(w_cnt - w0), 4'(b_cnt - b0), 4'(ar_cnt - ar0), 4'(r_cnt - r0)},
          v.wr ? 20'h11100 : 20'h00011);
    W_READY = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = mk(1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 32'h0,        2'b00);
    vecs[1]  = mk(0, 4'h4, 32'h0,        4'h0, 2'b00, 0, 0, 32'hDEADBEEF, 2'b00);
    vecs[2]  = mk(1, 4'h8, 32'h12345678, 4'hF, 2'b00, 3, 0, 32'h0,        2'b00);
    vecs[3]  = mk(0, 4'h8, 32'h0,        4'h0, 2'b00, 0, 5, 32'h12345678, 2'b00);
    vecs[4]  = mk(1, 4'h8, 32'hAABBCCDD, 4'h5, 2'b00, 0, 0, 32'h0,        2'b00);
    vecs[5]  = mk(0, 4'h8, 32'h0,        4'h0, 2'b00, 0, 0, 32'h12BB56DD, 2'b00);
    vecs[6]  = mk(1, 4'hC, 32'h000000FF, 4'hF, 2'b10, 0, 0, 32'h0,        2'b10);
    vecs[7]  = mk(0, 4'hC, 32'h0,        4'h0, 2'b10, 0, 0, 32'h000000FF, 2'b10);
    vecs[8]  = mk(0, 4'h0, 32'h0,        4'h0, 2'b00, 0, 0, 32'h0,        2'b00);
    vecs[9]  = mk(1, 4'h0, 32'hCAFEF00D, 4'hC, 2'b00, 0, 0, 32'h0,        2'b00);
    vecs[10] = mk(0, 4'h0, 32'h0,        4'h0, 2'b00, 0, 2, 32'hCAFE0000, 2'b00);
    vecs[11] = mk(0, 4'h4, 32'h0,        4'h0, 2'b01, 0, 0, 32'hDEADBEEF, 2'b01);

    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; AW_READY = 1'b1; W_READY = 1'b1; AR_READY = 1'b1;

    // reset state
    repeat (3) @(negedge ACLK);
    check("reset_ctrl",
          {cmd_ready, rsp_valid, rsp_resp, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
           dbg_state_o, AW_ADDR, AR_ADDR, W_STRB}, 64'd0);
    check("reset_data", {rsp_rdata, W_DATA}, 64'd0);
    ARST_N = 1'b1;
    @(negedge ACLK);
    check("ready_after_release", {cmd_ready, dbg_state_o}, {1'b1, 3'd0});

    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // reset asserted while waiting for B: everything returns to reset values at once
    b_en = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!B_READY && n < 20) begin @(negedge ACLK); n++; end
    check("reached_wr_b", {B_READY, dbg_state_o}, {1'b1, 3'd2});
    #2 ARST_N = 1'b0;
    #1;
    check("async_reset_ctrl",
          {cmd_ready, rsp_valid, rsp_resp, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
           dbg_state_o, AW_ADDR, AR_ADDR, W_STRB}, 64'd0);
    check("async_reset_data", {rsp_rdata, W_DATA}, 64'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    check("ready_low_in_reset", 64'(cmd_ready), 64'd0);
    b_en = 1'b1;
    ARST_N = 1'b1;
    @(negedge ACLK);
    check("ready_after_rerelease", {cmd_ready, dbg_state_o}, {1'b1, 3'd0});
    // slave memory was cleared by the same reset
    run_cmd(mk(0, 4'h4, 32'h0,        4'h0, 2'b00, 0, 0, 32'h0,        2'b00));
    run_cmd(mk(1, 4'h4, 32'h01020304, 4'hF, 2'b00, 0, 0, 32'h0,        2'b00));
    run_cmd(mk(0, 4'h4, 32'h0,        4'h0, 2'b00, 0, 1, 32'h01020304, 2'b00));

`ifdef AXIL_TIMEOUT_EN
    begin : timeout_seq
      int c, hi, ar0;
      logic [33:0] exp;
      AR_READY = 1'b0;
      ar0 = ar_cnt;
      exp_q.push_back({32'h0, 2'b11});
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h8;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
      cmd_valid = 1'b0;
      c = 1; hi = 0;
      while (AR_VALID && c < 100) begin
        hi++;
        @(negedge ACLK);
        c++;
      end
      check("timeout_ar_high_cycles", 64'(hi), 64'(TO));
      check("timeout_ar_addr_ready", {AR_VALID, R_READY, 4'(ar_cnt - ar0)}, 6'b0);
      exp = exp_q.pop_front();
      check("timeout_rsp", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, exp});
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
      AR_READY = 1'b1;
      check("timeout_idle", {rsp_valid, cmd_ready}, 2'b01);
    end
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
